// File: rtl/display_mmio_pkg.sv
// Shared register map, control bit indices, status layout and small helpers
// for the memory-mapped display peripheral.
package display_mmio_pkg;

    // Register offsets from the peripheral base address
    localparam logic [31:0] OFS_DATA = 32'h0000_0000;
    localparam logic [31:0] OFS_CTRL = 32'h0000_0004;

    // CTRL store bit indices
    localparam int CTRL_BYPASS  = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    // STATUS load field positions: {24'b0, count[3:0], overflow, full, empty, bypass}
    localparam int ST_BYPASS    = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;

    // Merge the enabled bytes of a store into the previous word
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  byte_en);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    // FIFO occupancy as reported in STATUS, saturating at 15
    function automatic logic [3:0] sat_count(input int unsigned n);
        logic [31:0] v;
        v = n;
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/display_fifo.sv
// Synchronous DEPTH x 32 FIFO with flush. A push into a full FIFO is still
// accepted when a pop happens in the same cycle, since the pop frees a slot.
module display_fifo
    import display_mmio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iPush,
    input  logic                       iPop,
    input  logic                       iFlush,
    input  logic [31:0]                iData,
    output logic [31:0]                oHead,
    output logic                       oFull,
    output logic                       oEmpty,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oPushOk
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign oFull     = (r_count == CNT_W'(DEPTH));
    assign oEmpty    = (r_count == '0);
    assign oCount    = r_count;
    assign oHead     = r_mem[r_rd_ptr];
    assign w_do_pop  = iPop & ~oEmpty & ~iFlush;
    assign w_do_push = iPush & ~iFlush & (~oFull | w_do_pop);
    assign oPushOk   = w_do_push;

    // Pointer and occupancy tracking; flush empties the FIFO and wins over push/pop
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (iFlush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage write port
    // NOTE: the data array has no reset; occupancy is tracked by the pointers, so stale words are never observed.
    always_ff @(posedge iCLK) begin
        if (w_do_push) r_mem[r_wr_ptr] <= iData;
    end

endmodule

// File: rtl/display_mmio_ctrl.sv
// Memory-mapped display peripheral: decodes DATA and CTRL/STATUS, merges byte
// stores into a shadow word, queues values and holds each on the display for
// at least DWELL_CYCLES. Bypass mode writes the display directly.
module display_mmio_ctrl
    import display_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFF00_0000,
    parameter int          DEPTH        = 4,
    parameter int          DWELL_CYCLES = 50_000_000,
    parameter int          DWELL_W      = 26
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iWrEn,
    input  logic        iRdEn,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    input  logic [3:0]  iByteEn,
    output logic [31:0] oRData,
    output logic [31:0] oOutput
);

    localparam logic [31:0]        DATA_ADDR  = BASE_ADDR + OFS_DATA;
    localparam logic [31:0]        CTRL_ADDR  = BASE_ADDR + OFS_CTRL;
    localparam int                 CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    logic [31:0]        r_shadow;
    logic [31:0]        r_output;
    logic [31:0]        r_rdata;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_bypass;
    logic               r_overflow;

    logic               w_sel_data;
    logic               w_sel_ctrl;
    logic               w_data_store;
    logic               w_ctrl_store;
    logic               w_bypass_store;
    logic               w_queue_store;
    logic               w_fifo_flush;
    logic               w_pop;
    logic [31:0]        w_merged;
    logic [31:0]        w_head;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_push_ok;
    logic [31:0]        w_status;
    logic               w_unused;

    // Word decode only: the byte offset within a register is irrelevant
    assign w_sel_data = (iAddr[31:2] == DATA_ADDR[31:2]);
    assign w_sel_ctrl = (iAddr[31:2] == CTRL_ADDR[31:2]);
    assign w_unused   = &{1'b0, iAddr[1:0]};

    assign w_merged       = byte_merge(r_shadow, iWData, iByteEn);
    assign w_data_store   = iWrEn & w_sel_data & (|iByteEn);
    assign w_ctrl_store   = iWrEn & w_sel_ctrl & iByteEn[0];
    assign w_bypass_store = w_data_store & r_bypass;
    assign w_queue_store  = w_data_store & ~r_bypass;

    // Entering bypass discards the queue so later direct writes are never overtaken by stale values
    assign w_fifo_flush = w_bypass_store |
                          (w_ctrl_store & (iWData[CTRL_BYPASS] | iWData[CTRL_FLUSH]));
    assign w_pop        = (r_dwell == '0) & ~w_empty & ~w_fifo_flush;

    display_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iPush   (w_queue_store),
        .iPop    (w_pop),
        .iFlush  (w_fifo_flush),
        .iData   (w_merged),
        .oHead   (w_head),
        .oFull   (w_full),
        .oEmpty  (w_empty),
        .oCount  (w_count),
        .oPushOk (w_push_ok)
    );

    // STATUS word assembled from live state
    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_status                                 = '0;
        w_status[ST_BYPASS]                      = r_bypass;
        w_status[ST_EMPTY]                       = w_empty;
        w_status[ST_FULL]                        = w_full;
        w_status[ST_OVF]                         = r_overflow;
        w_status[ST_COUNT_LSB +: ST_COUNT_W]     = sat_count(32'(w_count));
    end

    // Shadow word follows every DATA store, whether or not the value is queued
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)              r_shadow <= '0;
        else if (w_data_store) r_shadow <= w_merged;
    end

    // Displayed value and dwell counter
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_output <= '0;
            r_dwell  <= '0;
        end else if (w_bypass_store) begin
            r_output <= w_merged;
            r_dwell  <= '0;
        end else if (w_pop) begin
            r_output <= w_head;
            r_dwell  <= DWELL_LOAD;
        end else if (r_dwell != '0) begin
            r_dwell  <= r_dwell - DWELL_W'(1);
        end
    end

    // Bypass mode and sticky overflow flag
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_bypass   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ctrl_store) begin
                r_bypass <= iWData[CTRL_BYPASS];
                if (iWData[CTRL_CLR_OVF]) r_overflow <= 1'b0;
            end
            if (w_queue_store & ~w_push_ok) r_overflow <= 1'b1;
        end
    end

    // Registered load data; reflects state before any same-cycle store
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)                     r_rdata <= '0;
        else if (iRdEn & w_sel_data)  r_rdata <= r_output;
        else if (iRdEn & w_sel_ctrl)  r_rdata <= w_status;
        else                          r_rdata <= '0;
    end

    assign oRData  = r_rdata;
    assign oOutput = r_output;

endmodule
